// File: rtl/fetch_stage.sv
// Fetch stage of a five-stage Y86-64 style pipeline.
// Selects the fetch PC (branch-mispredict / return redirects take priority
// over the predicted PC), splits and aligns the instruction bytes, computes
// valC / valP / status, predicts the next PC and loads the D pipeline register.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        F_stall_i,
    input  logic        D_stall_i,
    input  logic        D_bubble_i,
    input  logic [3:0]  M_icode_i,
    input  logic        M_cnd_i,
    input  logic [63:0] M_valA_i,
    input  logic [3:0]  W_icode_i,
    input  logic [63:0] W_valM_i,
    input  logic [79:0] instr_i,
    input  logic        imem_error_i,
    output logic [63:0] f_pc_o,
    output logic [63:0] f_predPC_o,
    output logic [2:0]  D_stat_o,
    output logic [3:0]  D_icode_o,
    output logic [3:0]  D_ifun_o,
    output logic [3:0]  D_rA_o,
    output logic [3:0]  D_rB_o,
    output logic [63:0] D_valC_o,
    output logic [63:0] D_valP_o
);

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] F_NONE   = 4'h0;
    localparam logic [3:0] REG_NONE = 4'hF;

    // Status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // ------------------------------------------------------------------
    // Instruction byte unpacking
    // ------------------------------------------------------------------
    logic [7:0]  instr_byte [0:9];
    logic [63:0] valc_after_regs;   // bytes 2..9, little-endian
    logic [63:0] valc_after_op;     // bytes 1..8, little-endian

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_bytes
            assign instr_byte[gi] = instr_i[8*gi +: 8];
        end
        for (gi = 0; gi < 8; gi++) begin : g_valc
            assign valc_after_regs[8*gi +: 8] = instr_byte[gi+2];
            assign valc_after_op[8*gi +: 8]   = instr_byte[gi+1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic [63:0] f_predpc_reg, f_predpc_next;
    logic [2:0]  d_stat_reg,  d_stat_next;
    logic [3:0]  d_icode_reg, d_icode_next;
    logic [3:0]  d_ifun_reg,  d_ifun_next;
    logic [3:0]  d_ra_reg,    d_ra_next;
    logic [3:0]  d_rb_reg,    d_rb_next;
    logic [63:0] d_valc_reg,  d_valc_next;
    logic [63:0] d_valp_reg,  d_valp_next;

    // ------------------------------------------------------------------
    // Fetch-stage combinational signals
    // ------------------------------------------------------------------
    logic [63:0] f_pc;
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic [3:0]  f_ra;
    logic [3:0]  f_rb;
    logic        need_regids;
    logic        need_valc;
    logic        instr_valid;
    logic [63:0] f_valc;
    logic [63:0] f_valp;
    logic [2:0]  f_stat;
    logic [63:0] f_pred;

    // Fetch PC: a not-taken jump in M was mispredicted, so fall through to
    // its valA; a ret in W supplies the return address; otherwise predicted.
    always_comb begin
        f_pc = f_predpc_reg;
        if (M_icode_i == I_JXX && !M_cnd_i) begin
            f_pc = M_valA_i;
        end else if (W_icode_i == I_RET) begin
            f_pc = W_valM_i;
        end
    end

    // Split byte 0 into icode/ifun; an address error turns the fetch into a nop
    always_comb begin
        f_icode = instr_byte[0][7:4];
        f_ifun  = instr_byte[0][3:0];
        if (imem_error_i) begin
            f_icode = I_NOP;
            f_ifun  = F_NONE;
        end
    end

    // Decode which optional fields the instruction carries
    always_comb begin
        need_regids = 1'b0;
        need_valc   = 1'b0;
        case (f_icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            I_JXX, I_CALL: need_valc = 1'b1;
            default: begin
                need_regids = 1'b0;
                need_valc   = 1'b0;
            end
        endcase
    end

    // Register specifiers default to "no register" when absent
    always_comb begin
        f_ra = REG_NONE;
        f_rb = REG_NONE;
        if (need_regids) begin
            f_ra = instr_byte[1][7:4];
            f_rb = instr_byte[1][3:0];
        end
    end

    // Constant word follows the register byte if there is one
    always_comb begin
        f_valc = 64'h0;
        if (need_valc) begin
            f_valc = need_regids ? valc_after_regs : valc_after_op;
        end
    end

    // Fall-through PC; plain 64-bit add so it wraps naturally
    always_comb begin
        f_valp = f_pc + 64'd1 + {63'd0, need_regids} + {60'd0, need_valc, 3'b000};
    end

    // Instruction status, highest-severity condition first
    always_comb begin
        instr_valid = (f_icode <= I_POPQ);
        if (imem_error_i) begin
            f_stat = STAT_ADR;
        end else if (!instr_valid) begin
            f_stat = STAT_INS;
        end else if (f_icode == I_HALT) begin
            f_stat = STAT_HLT;
        end else begin
            f_stat = STAT_AOK;
        end
    end

    // Jumps are predicted taken and calls go to their target
    always_comb begin
        f_pred = (f_icode == I_JXX || f_icode == I_CALL) ? f_valc : f_valp;
    end

    // Next predicted PC: hold while fetch is stalled
    always_comb begin
        f_predpc_next = F_stall_i ? f_predpc_reg : f_pred;
    end

    // D register next value: stall beats bubble, bubble beats normal load
    always_comb begin
        d_stat_next  = d_stat_reg;
        d_icode_next = d_icode_reg;
        d_ifun_next  = d_ifun_reg;
        d_ra_next    = d_ra_reg;
        d_rb_next    = d_rb_reg;
        d_valc_next  = d_valc_reg;
        d_valp_next  = d_valp_reg;
        if (!D_stall_i) begin
            if (D_bubble_i) begin
                d_stat_next  = STAT_AOK;
                d_icode_next = I_NOP;
                d_ifun_next  = F_NONE;
                d_ra_next    = REG_NONE;
                d_rb_next    = REG_NONE;
                d_valc_next  = 64'h0;
                d_valp_next  = 64'h0;
            end else begin
                d_stat_next  = f_stat;
                d_icode_next = f_icode;
                d_ifun_next  = f_ifun;
                d_ra_next    = f_ra;
                d_rb_next    = f_rb;
                d_valc_next  = f_valc;
                d_valp_next  = f_valp;
            end
        end
    end

    // Predicted-PC register; reset takes effect immediately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            f_predpc_reg <= RESET_PC;
        end else begin
            f_predpc_reg <= f_predpc_next;
        end
    end

    // D pipeline register; reset loads a bubble immediately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_stat_reg  <= STAT_AOK;
            d_icode_reg <= I_NOP;
            d_ifun_reg  <= F_NONE;
            d_ra_reg    <= REG_NONE;
            d_rb_reg    <= REG_NONE;
            d_valc_reg  <= 64'h0;
            d_valp_reg  <= 64'h0;
        end else begin
            d_stat_reg  <= d_stat_next;
            d_icode_reg <= d_icode_next;
            d_ifun_reg  <= d_ifun_next;
            d_ra_reg    <= d_ra_next;
            d_rb_reg    <= d_rb_next;
            d_valc_reg  <= d_valc_next;
            d_valp_reg  <= d_valp_next;
        end
    end

    assign f_pc_o     = f_pc;
    assign f_predPC_o = f_predpc_reg;
    assign D_stat_o   = d_stat_reg;
    assign D_icode_o  = d_icode_reg;
    assign D_ifun_o   = d_ifun_reg;
    assign D_rA_o     = d_ra_reg;
    assign D_rB_o     = d_rb_reg;
    assign D_valC_o   = d_valc_reg;
    assign D_valP_o   = d_valp_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the stimulus process pushes the
// hand-computed D/predPC contents expected after each clock, and a monitor
// pops and compares one entry per clock edge.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        F_stall_i = 1'b0;
    logic        D_stall_i = 1'b0;
    logic        D_bubble_i = 1'b0;
    logic [3:0]  M_icode_i = 4'h0;
    logic        M_cnd_i = 1'b0;
    logic [63:0] M_valA_i = 64'h0;
    logic [3:0]  W_icode_i = 4'h0;
    logic [63:0] W_valM_i = 64'h0;
    logic [79:0] instr_i = 80'h0;
    logic        imem_error_i = 1'b0;
    logic [63:0] f_pc_o;
    logic [63:0] f_predPC_o;
    logic [2:0]  D_stat_o;
    logic [3:0]  D_icode_o;
    logic [3:0]  D_ifun_o;
    logic [3:0]  D_rA_o;
    logic [3:0]  D_rB_o;
    logic [63:0] D_valC_o;
    logic [63:0] D_valP_o;

    fetch_stage #(.RESET_PC(64'h0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .F_stall_i(F_stall_i), .D_stall_i(D_stall_i), .D_bubble_i(D_bubble_i),
        .M_icode_i(M_icode_i), .M_cnd_i(M_cnd_i), .M_valA_i(M_valA_i),
        .W_icode_i(W_icode_i), .W_valM_i(W_valM_i),
        .instr_i(instr_i), .imem_error_i(imem_error_i),
        .f_pc_o(f_pc_o), .f_predPC_o(f_predPC_o),
        .D_stat_o(D_stat_o), .D_icode_o(D_icode_o), .D_ifun_o(D_ifun_o),
        .D_rA_o(D_rA_o), .D_rB_o(D_rB_o), .D_valC_o(D_valC_o), .D_valP_o(D_valP_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [63:0] predpc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic exp_t ex(input logic [2:0] s, input logic [3:0] ic, input logic [3:0] fn,
                                input logic [3:0] a, input logic [3:0] b,
                                input logic [63:0] c, input logic [63:0] p, input logic [63:0] pp);
        exp_t e;
        e = {s, ic, fn, a, b, c, p, pp};
        return e;
    endfunction

    function automatic logic [79:0] ins(input logic [7:0] b0, input logic [7:0] b1, input logic [63:0] rest);
        return {rest, b1, b0};
    endfunction

    function automatic exp_t observed();
        exp_t g;
        g = {D_stat_o, D_icode_o, D_ifun_o, D_rA_o, D_rB_o, D_valC_o, D_valP_o, f_predPC_o};
        return g;
    endfunction

    // Bubble values, used for reset and D_bubble checks
    localparam exp_t BUB = {3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0};

    task automatic check_d_now(input string name, input exp_t e);
        exp_t g;
        g = observed();
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", name, g, e);
        end else begin
            $display("vec %0d %s ok", vectors, name);
        end
    endtask

    task automatic check_pc(input string name, input logic [63:0] e);
        vectors++;
        if (f_pc_o !== e) begin
            miscompares++;
            $display("FAIL %s f_pc_o got=%h exp=%h", name, f_pc_o, e);
        end else begin
            $display("vec %0d %s f_pc_o=%h ok", vectors, name, f_pc_o);
        end
    endtask

    // Drive one fetch cycle and queue what D/predPC must hold after the edge
    task automatic step(input logic [79:0] iv, input logic err, input logic fst,
                        input logic dst, input logic dbub, input exp_t e);
        instr_i      = iv;
        imem_error_i = err;
        F_stall_i    = fst;
        D_stall_i    = dst;
        D_bubble_i   = dbub;
        sb.push_back(e);
        @(posedge clk_i);
        #2;
    endtask

    // Monitor: one scoreboard entry per rising edge, sampled 1 time unit later
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                exp_t g;
                e = sb.pop_front();
                g = observed();
                vectors++;
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL dreg stat=%0d icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h predPC=%h exp stat=%0d icode=%h ifun=%h rA=%h rB=%h valC=%h valP=%h predPC=%h",
                             g.stat, g.icode, g.ifun, g.ra, g.rb, g.valc, g.valp, g.predpc,
                             e.stat, e.icode, e.ifun, e.ra, e.rb, e.valc, e.valp, e.predpc);
                end else begin
                    $display("vec %0d dreg icode=%h valP=%h predPC=%h ok", vectors, g.icode, g.valp, g.predpc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    exp_t halt_e;

    initial begin
        // Reset state
        #12;
        check_d_now("reset_state", BUB);
        check_pc("reset_pc", 64'h0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;

        // irmovq $0x10,%rdx at 0
        step(ins(8'h30, 8'hF2, 64'h10), 0, 0, 0, 0, ex(3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'h10, 64'hA, 64'hA));
        // jmp 0x1E at 0xA
        step(ins(8'h70, 8'h1E, 64'h0), 0, 0, 0, 0, ex(3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h1E, 64'h13, 64'h1E));
        // jmp 0x27 at 0x1E
        step(ins(8'h70, 8'h27, 64'h0), 0, 0, 0, 0, ex(3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h27, 64'h27, 64'h27));
        // addq %rax,%rbx at 0x27
        step(ins(8'h60, 8'h03, 64'h0), 0, 0, 0, 0, ex(3'd1, 4'h6, 4'h0, 4'h0, 4'h3, 64'h0, 64'h29, 64'h29));

        // PC selection priority
        M_icode_i = 4'h7; M_cnd_i = 1'b0; M_valA_i = 64'h32; W_icode_i = 4'h9; W_valM_i = 64'h80;
        #1 check_pc("sel_mispredict", 64'h32);
        M_icode_i = 4'h0;
        #1 check_pc("sel_ret", 64'h80);
        W_icode_i = 4'h0;
        #1 check_pc("sel_pred", 64'h29);
        M_icode_i = 4'h7; M_cnd_i = 1'b1;
        #1 check_pc("sel_taken_jump", 64'h29);
        M_cnd_i = 1'b0;
        #1;
        // Redirect with F stalled: fetch from 0x32, predPC held
        step(ins(8'h10, 8'h00, 64'h0), 0, 1, 0, 0, ex(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h33, 64'h29));
        M_icode_i = 4'h0;

        // Status cases
        step(ins(8'h30, 8'hF2, 64'h10), 1, 0, 0, 0, ex(3'd3, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h2A, 64'h2A));
        step(ins(8'hC0, 8'h00, 64'h0), 0, 0, 0, 0, ex(3'd4, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h2B, 64'h2B));
        halt_e = ex(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h2C, 64'h2C);
        step(ins(8'h00, 8'h00, 64'h0), 0, 0, 0, 0, halt_e);

        // Full stall for three cycles
        for (int i = 0; i < 3; i++) begin
            step(ins(8'h30, 8'hF2, 64'h10), 0, 1, 1, 0, halt_e);
        end
        // Stall beats bubble; F advances from 0x2C
        step(ins(8'h10, 8'h00, 64'h0), 0, 0, 1, 1, ex(3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h2C, 64'h2D));
        // Bubble only; F advances from 0x2D over a 2-byte op
        step(ins(8'h60, 8'h03, 64'h0), 0, 0, 0, 1, ex(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h2F));
        // call 0x100 at 0x2F
        step(ins(8'h80, 8'h00, 64'h1), 0, 0, 0, 0, ex(3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h38, 64'h100));
        // Redirect to the top address: valP wraps to 0
        M_icode_i = 4'h7; M_cnd_i = 1'b0; M_valA_i = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 check_pc("sel_top", 64'hFFFF_FFFF_FFFF_FFFF);
        step(ins(8'h10, 8'h00, 64'h0), 0, 0, 0, 0, ex(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0));
        M_icode_i = 4'h0;
        step(ins(8'h60, 8'h03, 64'h0), 0, 0, 0, 0, ex(3'd1, 4'h6, 4'h0, 4'h0, 4'h3, 64'h0, 64'h2, 64'h2));

        // Asynchronous reset between edges
        #1 rst_i = 1'b1;
        #1 check_d_now("async_reset", BUB);
        check_pc("async_reset_pc", 64'h0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1 check_pc("post_reset_pc", 64'h0);
        // irmovq with full 8-byte constant, checks byte order
        step(ins(8'h30, 8'hF3, 64'h1122_3344_5566_7788), 0, 0, 0, 0,
             ex(3'd1, 4'h3, 4'h0, 4'hF, 4'h3, 64'h1122_3344_5566_7788, 64'hA, 64'hA));

        // Drain scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk_i);
        #2;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain remaining=%0d required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 64'h0, value loaded into F_predPC on reset.
REQ-002 SHALL have ports (name direction width meaning):
- clk_i in 1: single clock; all state updates on rising edge.
- rst_i in 1: reset, asynchronous, active-high.
- F_stall_i in 1: hold F_predPC.
- D_stall_i in 1: hold D register.
- D_bubble_i in 1: load nop bubble into D register.
- M_icode_i in 4: memory-stage icode.
- M_cnd_i in 1: memory-stage condition result.
- M_valA_i in 64: memory-stage valA (fall-through PC of a jump).
- W_icode_i in 4: write-back-stage icode.
- W_valM_i in 64: write-back-stage valM (return address).
- instr_i in 80: 10 instruction bytes from instruction memory; byte k = instr_i[8k+7:8k].
- imem_error_i in 1: instruction memory address error.
- f_pc_o out 64: fetch address to instruction memory.
- f_predPC_o out 64: current F_predPC register value.
- D_stat_o out 3, D_icode_o out 4, D_ifun_o out 4, D_rA_o out 4, D_rB_o out 4, D_valC_o out 64, D_valP_o out 64: D pipeline register contents.

Function
REQ-003 f_pc_o SHALL be combinational with priority order:
- M_valA_i when M_icode_i==4'h7 and M_cnd_i==0;
- else W_valM_i when W_icode_i==4'h9;
- else F_predPC.
REQ-004 Split SHALL be: icode=byte0[7:4], ifun=byte0[3:0], rA=byte1[7:4], rB=byte1[3:0].
REQ-005 When imem_error_i=1, split SHALL force icode=4'h1 and ifun=4'h0.
REQ-006 need_regids SHALL be 1 for icode in {2,3,4,5,6,A,B}; need_valC SHALL be 1 for icode in {3,4,5,7,8}.
REQ-007 When need_regids=0, rA and rB SHALL be 4'hF.
REQ-008 valC SHALL be little-endian bytes 2..9 when need_regids=1, else bytes 1..8; valC SHALL be 0 when need_valC=0.
REQ-009 valP SHALL be f_pc + 1 + need_regids + 8*need_valC, 64-bit, wrapping modulo 2^64.
REQ-010 instr_valid SHALL be 1 for icode 0..B.
REQ-011 f_stat SHALL be (first match): 3'd3 ADR if imem_error_i; else 3'd4 INS if !instr_valid; else 3'd2 HLT if icode==0; else 3'd1 AOK.
REQ-012 Predicted PC SHALL be valC for icode 7 or 8, else valP.
REQ-013 F_predPC SHALL load the predicted PC each cycle unless F_stall_i=1, in which case it holds.
REQ-014 D register SHALL update each cycle with priority:
- D_stall_i=1: hold all fields (stall wins over bubble);
- else D_bubble_i=1: load bubble (stat=1, icode=1, ifun=0, rA=rB=F, valC=0, valP=0);
- else: load f_stat, icode, ifun, rA, rB, valC, valP.
REQ-015 Latency SHALL be one cycle from f_pc_o/instr_i to the D outputs; f_predPC_o SHALL be the registered value.
REQ-016 Simultaneous F_stall_i and M/W redirect: f_pc_o SHALL still follow REQ-003; only the F_predPC update is suppressed.

Reset
REQ-017 While rst_i=1, asynchronously: F_predPC=RESET_PC and D register = bubble values of REQ-014.
REQ-018 Assertion of rst_i mid-operation SHALL discard in-flight state without waiting for a clock edge.
REQ-019 First rising edge after deassertion SHALL fetch from RESET_PC.

Verification
REQ-020 Reset, instr_i=30 f2 10 00 00 00 00 00 00 00 at PC 0, one clock -> D_icode=3, D_ifun=0, D_rA=F, D_rB=2, D_valC=0x10, D_valP=0xA, D_stat=1, f_predPC_o=0xA.
REQ-021 F_predPC=0x1E, instr_i=70 27 00.. -> D_valP=0x27, D_rA=D_rB=F, f_predPC_o=0x27; then instr_i=60 03 -> D_valP=0x29, D_rA=0, D_rB=3.
REQ-022 M_icode_i=7, M_cnd_i=0, M_valA_i=0x32, W_icode_i=9 -> f_pc_o=0x32; clearing M_icode_i with W_valM_i=0x80 -> f_pc_o=0x80; both inactive -> f_pc_o=F_predPC.
REQ-023 imem_error_i=1 -> D_stat=3, D_icode=1, D_ifun=0; instr_i byte0=0xC0 -> D_stat=4; byte0=0x00 -> D_stat=2, D_valP=F_predPC+1.
REQ-024 F_stall_i=D_stall_i=1 for 3 cycles -> f_predPC_o and all D outputs constant; D_stall_i=D_bubble_i=1 -> hold; D_bubble_i only -> D_icode=1, D_stat=1, D_rA=D_rB=F.
REQ-025 rst_i pulsed between clock edges mid-run -> f_predPC_o=0 and D bubble values immediately; first fetch after release at 0.
